// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an internal register-file memory with occupancy and almost-full/almost-empty flags.
// Optional sticky overflow/underflow flags are compiled in when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_ram #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
);

  localparam int            DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_dout_p1;
  logic              r_vld_p1;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flags come straight from the registered count, so input activity cannot glitch them.
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;
  assign dout         = r_dout_p1;
  assign dout_valid   = r_vld_p1;

  // Storage carries no reset; stale entries are unreachable while empty.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ONE_C;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ONE_C;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read stage: one-cycle registered output.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_dout_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout_p1 <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed self-checking bench for sync_fifo_ram (default 16x8 geometry).
// Error-flag checks are included only when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_ram;

  logic        clk;
  logic        clr_n;
  logic        wr_en;
  logic [15:0] din;
  logic        rd_en;
  logic [15:0] dout;
  logic        dout_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
`ifdef FIFO_ERR_FLAGS_EN
  logic        err_clr;
  logic        overflow;
  logic        underflow;
`endif

  int n_chk;
  int n_err;

  sync_fifo_ram #(
    .DATA_W(16), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .wr_en(wr_en),
    .din(din),
    .rd_en(rd_en),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr(err_clr),
    .overflow(overflow),
    .underflow(underflow),
`endif
    .dout(dout),
    .dout_valid(dout_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en = 1'b1;
    din   = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check({tag, "_dout"}, 32'(dout), 32'(exp));
    check({tag, "_vld"}, 32'(dout_valid), 1);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    clr_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    step();
    step();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_vld", 32'(dout_valid), 0);
    clr_n = 1'b1;

    // Fill 1..8 and watch the flags at every level
    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
      check("fill_count", 32'(count), 32'(i));
      check("fill_full", 32'(full), (i == 8) ? 1 : 0);
      check("fill_af", 32'(almost_full), (i >= 6) ? 1 : 0);
      check("fill_ae", 32'(almost_empty), (i <= 2) ? 1 : 0);
      check("fill_empty", 32'(empty), 0);
    end

    for (int i = 1; i <= 8; i++) begin
      pop_check("drain", 16'(i));
      check("drain_count", 32'(count), 32'(8 - i));
      check("drain_empty", 32'(empty), (i == 8) ? 1 : 0);
    end
    step();
    check("idle_vld", 32'(dout_valid), 0);
    check("idle_hold", 32'(dout), 32'h0008);

    // Wrap: pointers cross entry 7 -> 0
    for (int i = 0; i < 5; i++) push(16'h0010 + 16'(i));
    for (int i = 0; i < 5; i++) pop_check("wrap5", 16'h0010 + 16'(i));
    for (int i = 0; i < 8; i++) push(16'h0020 + 16'(i));
    check("wrap_full", 32'(full), 1);
    for (int i = 0; i < 8; i++) pop_check("wrap8", 16'h0020 + 16'(i));
    check("wrap_empty", 32'(empty), 1);

    // Full + simultaneous rd/wr: read wins, write dropped
    for (int i = 0; i < 8; i++) push(16'h0030 + 16'(i));
    rd_en = 1'b1;
    wr_en = 1'b1;
    din   = 16'hBEEF;
    step();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("fullrw_dout", 32'(dout), 32'h0030);
    check("fullrw_vld", 32'(dout_valid), 1);
    check("fullrw_count", 32'(count), 7);
    for (int i = 1; i < 8; i++) pop_check("fullrw_drain", 16'h0030 + 16'(i));
    check("fullrw_empty", 32'(empty), 1);

    // Empty + simultaneous rd/wr: write wins, read dropped
    rd_en = 1'b1;
    wr_en = 1'b1;
    din   = 16'h1234;
    step();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("emptyrw_count", 32'(count), 1);
    check("emptyrw_vld", 32'(dout_valid), 0);
    check("emptyrw_hold", 32'(dout), 32'h0037);
    pop_check("emptyrw_read", 16'h1234);

    // Streaming at count 4: output is the input delayed by four words
    for (int i = 0; i < 4; i++) push(16'h0040 + 16'(i));
    for (int k = 0; k < 20; k++) begin
      rd_en = 1'b1;
      wr_en = 1'b1;
      din   = 16'h0050 + 16'(k);
      step();
      check("stream_count", 32'(count), 4);
      check("stream_dout", 32'(dout), (k < 4) ? 32'h0040 + 32'(k) : 32'h0050 + 32'(k - 4));
      check("stream_vld", 32'(dout_valid), 1);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) pop_check("stream_tail", 16'h0060 + 16'(i));

    // Asynchronous reset mid-transfer discards buffered words
    for (int i = 0; i < 3; i++) push(16'h0070 + 16'(i));
    #2;
    clr_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_ae", 32'(almost_empty), 1);
    check("arst_full", 32'(full), 0);
    check("arst_dout", 32'(dout), 0);
    check("arst_vld", 32'(dout_valid), 0);
    step();
    clr_n = 1'b1;
    push(16'hAAAA);
    push(16'hBBBB);
    check("post_rst_count", 32'(count), 2);
    pop_check("post_rst0", 16'hAAAA);
    pop_check("post_rst1", 16'hBBBB);

`ifdef FIFO_ERR_FLAGS_EN
    check("err_init_ovf", 32'(overflow), 0);
    check("err_init_udf", 32'(underflow), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("err_udf", 32'(underflow), 1);
    for (int i = 0; i < 8; i++) push(16'(i));
    check("err_no_ovf", 32'(overflow), 0);
    push(16'hDEAD);
    check("err_ovf", 32'(overflow), 1);
    check("err_ovf_count", 32'(count), 8);
    step();
    check("err_ovf_held", 32'(overflow), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_ovf", 32'(overflow), 0);
    check("err_clr_udf", 32'(underflow), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
